// File: rtl/eq_sync_capture.sv
// eq_sync_capture: dual-rail completion capture with DATA/NULL phasing and valid/ready result; EQ_CAPTURE_STAT_EN adds capture counters
module eq_sync_capture #(
    parameter int WIDTH = 8,
    parameter int TIMEOUT = 255,
    localparam int RAIL_NUM = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH*RAIL_NUM-1:0] in,
    output logic                      en,
    input  logic                      start,
    output logic                      busy,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_eq,
    output logic [WIDTH-1:0]          res_mask,
    output logic [1:0]                err,
    input  logic                      err_clr
`ifdef EQ_CAPTURE_STAT_EN
    ,
    output logic [15:0]               cmp_cnt,
    output logic [15:0]               mism_cnt
`endif
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE = 2'd0, EVAL = 2'd1, NULLW = 2'd2;

    logic [WIDTH*RAIL_NUM-1:0] s1_q, s2_q, stab_q;
    logic [WIDTH-1:0]          t_rail, f_rail, mask_q, mask_d;
    logic [1:0]                state_q, state_d, err_q, err_d, err_set;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      stable, all_data, all_null, any_ill, tmo;
    logic                      valid_q, valid_d, eq_q, eq_d, en_q;

    // two-flop synchroniser per rail plus a stability sample one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            stab_q <= '0;
        end else begin
            s1_q   <= in;
            s2_q   <= s1_q;
            stab_q <= s2_q;
        end
    end

    // split the synchronised pairs into true-rail and false-rail vectors
    always_comb begin
        t_rail = '0;
        f_rail = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t_rail[i] = s2_q[RAIL_NUM*i+1];
            f_rail[i] = s2_q[RAIL_NUM*i];
        end
    end

    assign stable   = s2_q == stab_q;
    assign all_data = stable && &(t_rail ^ f_rail);
    assign all_null = stable && !(|s2_q);
    assign any_ill  = stable && |(t_rail & f_rail);
    assign tmo      = cnt_q >= CW'(TIMEOUT - 1);

    // phase sequencing, result capture, consume and sticky error collection
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
        valid_d = valid_q && !res_ready;
        eq_d    = eq_q;
        mask_d  = mask_q;
        err_set = 2'b00;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start && !valid_q) state_d = EVAL;
            end
            EVAL: begin
                if (any_ill) begin
                    err_set[0] = 1'b1;
                    state_d    = NULLW;
                end else if (all_data) begin
                    valid_d = 1'b1;
                    mask_d  = t_rail;
                    eq_d    = &t_rail;
                    state_d = NULLW;
                end else if (tmo) begin
                    err_set[1] = 1'b1;
                    state_d    = NULLW;
                end
            end
            NULLW: begin
                if (all_null) begin
                    state_d = IDLE;
                end else if (tmo) begin
                    err_set[1] = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
        err_d = (err_clr ? 2'b00 : err_q) | err_set;
    end

    // control and result registers; en is registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            eq_q    <= 1'b0;
            mask_q  <= '0;
            err_q   <= 2'b00;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            eq_q    <= eq_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            en_q    <= state_d == EVAL;
        end
    end

    assign en        = en_q;
    assign busy      = state_q != IDLE;
    assign res_valid = valid_q;
    assign res_eq    = eq_q;
    assign res_mask  = mask_q;
    assign err       = err_q;

`ifdef EQ_CAPTURE_STAT_EN
    logic        cap;
    logic [15:0] cmp_q, mism_q;

    assign cap = state_q == EVAL && !any_ill && all_data;

    // saturating counts of captures and of captures that found a mismatch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_q  <= '0;
            mism_q <= '0;
        end else begin
            if (cap && cmp_q != 16'hFFFF) cmp_q <= cmp_q + 1'b1;
            if (cap && !(&t_rail) && mism_q != 16'hFFFF) mism_q <= mism_q + 1'b1;
        end
    end

    assign cmp_cnt  = cmp_q;
    assign mism_cnt = mism_q;
`endif
endmodule

// File: tb/tb_eq_sync_capture.sv
// tb_eq_sync_capture: directed and randomized checks of eq_sync_capture against a phase-level reference model
module tb_eq_sync_capture;
    localparam int W = 8, TO = 8;
    localparam int P_IDLE = 0, P_DATA = 1, P_NULL = 2;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, res_ready = 1'b0, err_clr = 1'b0;
    logic [2*W-1:0] din = '0;
    logic en, busy, res_valid, res_eq;
    logic [W-1:0] res_mask;
    logic [1:0] err;
`ifdef EQ_CAPTURE_STAT_EN
    logic [15:0] cmp_cnt, mism_cnt;
`endif

    int n_cmp = 0, n_mis = 0;

    // reference model: input history, phase, time in phase, result and error state
    logic [2*W-1:0] hist [3];
    int m_ph, m_tm, m_cmp, m_mis;
    logic m_valid, m_eq;
    logic [W-1:0] m_mask;
    logic [1:0] m_err;

    // upstream emulation: target code word, per-pair settle delays, stuck modes
    logic [2*W-1:0] word = '0;
    int dly [W];
    bit stall = 0, hold = 0;
    logic last_en = 1'b0;
    int en_age = 0;

    eq_sync_capture #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in(din), .en(en), .start(start), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .res_eq(res_eq),
        .res_mask(res_mask), .err(err), .err_clr(err_clr)
`ifdef EQ_CAPTURE_STAT_EN
        , .cmp_cnt(cmp_cnt), .mism_cnt(mism_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '0;
        m_ph = P_IDLE; m_tm = 0; m_cmp = 0; m_mis = 0;
        m_valid = 0; m_eq = 0; m_mask = '0; m_err = 2'b00;
    endtask

    // controller sees the input sampled two edges back; it is stable when equal to three edges back
    task automatic model_step();
        logic [2*W-1:0] seen;
        logic [1:0] set, code;
        bit stb, dat, nul, ill, was_valid;
        if (!rst) begin
            model_reset();
            return;
        end
        seen = hist[1];
        stb = seen == hist[2];
        dat = stb; nul = stb && seen == '0; ill = 0;
        for (int i = 0; i < W; i++) begin
            code = seen[2*i +: 2];
            if (code == 2'b11) ill = stb;
            if (code == 2'b11 || code == 2'b00) dat = 0;
        end
        set = 2'b00;
        was_valid = m_valid;
        if (m_valid && res_ready) m_valid = 0;
        case (m_ph)
            P_IDLE: if (start && !was_valid) begin m_ph = P_DATA; m_tm = 0; end
            P_DATA: begin
                m_tm++;
                if (ill) begin
                    set[0] = 1; m_ph = P_NULL; m_tm = 0;
                end else if (dat) begin
                    m_valid = 1;
                    for (int i = 0; i < W; i++) m_mask[i] = seen[2*i+1];
                    m_eq = m_mask == '1;
                    if (m_cmp < 65535) m_cmp++;
                    if (!m_eq && m_mis < 65535) m_mis++;
                    m_ph = P_NULL; m_tm = 0;
                end else if (m_tm >= TO) begin
                    set[1] = 1; m_ph = P_NULL; m_tm = 0;
                end
            end
            default: begin
                m_tm++;
                if (nul) begin
                    m_ph = P_IDLE; m_tm = 0;
                end else if (m_tm >= TO) begin
                    set[1] = 1; m_ph = P_IDLE; m_tm = 0;
                end
            end
        endcase
        m_err = (err_clr ? 2'b00 : m_err) | set;
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = din;
    endtask

    task automatic compare();
        chk("en", 32'(en), 32'(m_ph == P_DATA));
        chk("busy", 32'(busy), 32'(m_ph != P_IDLE));
        chk("res_valid", 32'(res_valid), 32'(m_valid));
        chk("res_eq", 32'(res_eq), 32'(m_eq));
        chk("res_mask", 32'(res_mask), 32'(m_mask));
        chk("err", 32'(err), 32'(m_err));
`ifdef EQ_CAPTURE_STAT_EN
        chk("cmp_cnt", 32'(cmp_cnt), 32'(m_cmp));
        chk("mism_cnt", 32'(mism_cnt), 32'(m_mis));
`endif
    endtask

    task automatic drive_upstream();
        if (en !== last_en) begin
            last_en = en;
            en_age = 0;
        end else en_age++;
        for (int i = 0; i < W; i++)
            if (en_age >= dly[i]) begin
                if (en && !(stall && i == 0)) din[2*i +: 2] = word[2*i +: 2];
                else if (!en && !hold) din[2*i +: 2] = 2'b00;
            end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        drive_upstream();
    endtask

    task automatic go(input logic [2*W-1:0] w);
        word = w;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("consumed", 32'(res_valid), 32'd0);
    endtask

    initial begin
        int lat, n;
        for (int i = 0; i < W; i++) dly[i] = 0;
        model_reset();
        #2 rst = 1'b0;
        repeat (3) tick();
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        repeat (2) tick();

        // all pairs TRUE with a zero-delay upstream
        go(16'hAAAA);
        lat = 0;
        while (!res_valid && lat < 50) begin tick(); lat++; end
        chk("t1_latency", 32'(lat), 32'd4);
        chk("t1_eq", 32'(res_eq), 32'd1);
        chk("t1_mask", 32'(res_mask), 32'hFF);
        chk("t1_en_low", 32'(en), 32'd0);
        wait_idle(n);
        consume();

        // pair 3 FALSE, result held unconsumed while a start is ignored
        go(16'hAA6A);
        wait_idle(n);
        for (int k = 0; k < 10; k++) begin
            start = k == 5;
            tick();
        end
        start = 1'b0;
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_valid", 32'(res_valid), 32'd1);
        chk("t2_eq", 32'(res_eq), 32'd0);
        chk("t2_mask", 32'(res_mask), 32'hF7);
        consume();

        // pair 0 FALSE
        go(16'hAAA9);
        wait_idle(n);
        chk("t2b_mask", 32'(res_mask), 32'hFE);
        consume();
`ifdef EQ_CAPTURE_STAT_EN
        chk("stat_cmp", 32'(cmp_cnt), 32'd3);
        chk("stat_mism", 32'(mism_cnt), 32'd2);
`endif

        // pair 5 illegal
        go(16'hAEAA);
        wait_idle(n);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_valid", 32'(res_valid), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_err_clr", 32'(err), 32'd0);

        // DATA never completes and rails never return to NULL
        stall = 1; hold = 1;
        go(16'hAAAA);
        lat = 0;
        while (en && lat < 50) begin tick(); lat++; end
        chk("t4_eval_cycles", 32'(lat), 32'd8);
        chk("t4_err", 32'(err), 32'd2);
        wait_idle(n);
        chk("t4_nullw_cycles", 32'(n), 32'd8);
        stall = 0; hold = 0;
        repeat (6) tick();

        // reset during EVAL with rails mid-transition
        for (int i = 0; i < W; i++) dly[i] = i % 4;
        go(16'hAAAA);
        tick();
        rst = 1'b0;
        #1;
        model_reset();
        chk("t5_en", 32'(en), 32'd0);
        chk("t5_valid", 32'(res_valid), 32'd0);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        repeat (6) tick();
        go(16'hAAAA);
        lat = 0;
        while (!res_valid && lat < 50) begin tick(); lat++; end
        chk("t5_valid_after", 32'(res_valid), 32'd1);
        chk("t5_eq_after", 32'(res_eq), 32'd1);
        wait_idle(n);
        consume();

        // randomized traffic
        for (int it = 0; it < 800; it++) begin
            if (!busy && $urandom_range(0, 3) == 0) begin
                for (int i = 0; i < W; i++) begin
                    int r;
                    r = $urandom_range(0, 19);
                    word[2*i +: 2] = r == 0 ? 2'b11 : (r < 10 ? 2'b10 : 2'b01);
                    dly[i] = $urandom_range(0, 5);
                end
                stall = $urandom_range(0, 29) == 0;
                hold = $urandom_range(0, 29) == 0;
                start = 1'b1;
            end else start = $urandom_range(0, 9) == 0;
            res_ready = $urandom_range(0, 2) == 0;
            err_clr = $urandom_range(0, 15) == 0;
            tick();
        end
        start = 1'b0; res_ready = 1'b0; err_clr = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
